cv32e40p_ex_issue_ctrl: RTL and testbench
=========================================

CV32E40P_EX_ISSUE_CTRL -- requirements
Module: cv32e40p_ex_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: cycles a unit may stay busy before an FT abort; range 2..255.
REQ-002 clk  in  1  clock.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 issue_valid_i  in  1  ID/EX register holds a new instruction this cycle.
REQ-005 alu_en_i / mult_en_i / data_req_i  in  1 each  unit enables latched in ID/EX.
REQ-006 alu_ready_i / mult_ready_i / lsu_ready_i  in  1 each  unit result available this cycle.
REQ-007 data_misaligned_i  in  1  LSU requests a second access.
REQ-008 wb_ready_i  in  1  WB stage accepts a result.
REQ-009 ex_ready_o  out  1  EX accepts the next ID/EX instruction.
REQ-010 ex_valid_o  out  1  result presented to WB.
REQ-011 mult_multicycle_o  out  1  multiplier holds operand C; ID/EX refreshes operand C.
REQ-012 data_misaligned_ex_o  out  1  second misaligned access in progress.
REQ-013 retired_cnt_o  out  32  count of instructions handed to WB.
REQ-014 ft_timeout_o  out  1  one-cycle pulse on watchdog abort.

Function
REQ-015 FSM states: IDLE, EXEC, MISAL, HOLD; encoding free.
REQ-016 done = AND over enabled units of their ready; an instruction with no enabled unit has done=1.
REQ-017 IDLE: ex_ready_o=1; issue_valid_i=1 -> EXEC next cycle, else stay.
REQ-018 EXEC, done=0: stay; ex_ready_o=0; mult_multicycle_o = mult_en_i & ~mult_ready_i.
REQ-019 EXEC, done=1, data_misaligned_i=1: -> MISAL; ex_ready_o=0; ex_valid_o=0.
REQ-020 EXEC/MISAL completion (done=1, no misalignment; in MISAL done=lsu_ready_i): wb_ready_i=1 -> ex_valid_o=1 and ex_ready_o=1 same cycle, next state EXEC if issue_valid_i else IDLE; wb_ready_i=0 -> HOLD.
REQ-021 MISAL: data_misaligned_ex_o=1; second misalignment request ignored.
REQ-022 HOLD: ex_valid_o=1, ex_ready_o=0 until wb_ready_i=1, then as REQ-020 completion.
REQ-023 Back-to-back: completion plus issue_valid_i in one cycle gives zero bubble.
REQ-024 retired_cnt_o increments by 1 on every ex_valid_o & wb_ready_i cycle; wraps 0xFFFFFFFF -> 0 with no flag.
REQ-025 Outputs ex_valid_o, ex_ready_o, mult_multicycle_o, data_misaligned_ex_o combinational from state and inputs; no input-to-output path other than ready/done terms above.

Reset
REQ-026 rst_n low: state IDLE, retired_cnt_o=0, ft_timeout_o=0, watchdog=0, immediately and regardless of clk.
REQ-027 During reset: ex_ready_o=1, ex_valid_o=0, mult_multicycle_o=0, data_misaligned_ex_o=0.
REQ-028 Reset mid-EXEC/MISAL/HOLD drops the instruction; no ex_valid_o, no count after deassertion.

Configuration
REQ-029 Macro CV32E40P_FT_EX_TIMEOUT_EN defined: 8-bit watchdog clears on entry to EXEC/MISAL, counts each cycle in EXEC/MISAL without completion; at TIMEOUT_CYCLES-1 forces completion per REQ-020 and pulses ft_timeout_o for that cycle.
REQ-030 Macro undefined: no watchdog logic; ft_timeout_o tied 0; a unit never ready stalls EX indefinitely.

Verification
REQ-031 Reset, then issue_valid_i=1 with alu_en_i=1, alu_ready_i=1, wb_ready_i=1 for 4 cycles -> ex_valid_o high 4 consecutive cycles, retired_cnt_o=4, ex_ready_o never low.
REQ-032 mult_en_i=1, mult_ready_i low 3 cycles -> mult_multicycle_o=1 for 3 cycles, ex_ready_o=0, ex_valid_o on the 4th cycle.
REQ-033 data_req_i=1, lsu_ready_i=1 with data_misaligned_i=1, then lsu_ready_i low 2 cycles -> data_misaligned_ex_o=1 for 3 cycles, single ex_valid_o, retired_cnt_o +1.
REQ-034 Completion with wb_ready_i=0 for 5 cycles -> HOLD, ex_valid_o stable 6 cycles, count +1 only on the accept cycle; preload count 0xFFFFFFFF -> 0 after accept.
REQ-035 With macro, TIMEOUT_CYCLES=8, alu_ready_i stuck 0 -> ft_timeout_o pulse at 8th EXEC cycle, ex_valid_o same cycle; without macro -> no pulse after 100 cycles.
REQ-036 rst_n asserted mid-EXEC (mult pending) -> ex_valid_o=0, state IDLE, retired_cnt_o=0 within the same cycle.

Source files
------------

// File: rtl/cv32e40p_ex_issue_ctrl.sv
// cv32e40p_ex_issue_ctrl
// Execute-stage issue/completion controller. It tracks one instruction held in
// the ID/EX register from issue until the WB stage accepts its result. It
// handles multi-cycle multiplier operations, the second access of a misaligned
// LSU transfer, and write-back back-pressure. It also keeps a retired-
// instruction counter.
//
// Optional feature: define CV32E40P_FT_EX_TIMEOUT_EN to add a watchdog. The
// watchdog forces completion after TIMEOUT_CYCLES cycles in EXEC/MISAL and
// pulses ft_timeout_o. When the macro is undefined, ft_timeout_o is tied to 0.
module cv32e40p_ex_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid_i,
  input  logic        alu_en_i,
  input  logic        mult_en_i,
  input  logic        data_req_i,
  input  logic        alu_ready_i,
  input  logic        mult_ready_i,
  input  logic        lsu_ready_i,
  input  logic        data_misaligned_i,
  input  logic        wb_ready_i,
  output logic        ex_ready_o,
  output logic        ex_valid_o,
  output logic        mult_multicycle_o,
  output logic        data_misaligned_ex_o,
  output logic [31:0] retired_cnt_o,
  output logic        ft_timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MISAL,
    S_HOLD
  } state_e;

  // TIMEOUT_CYCLES must fit the 8-bit watchdog and leave at least one cycle
  // before the forced completion.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..255");
  end

  state_e      r_state;
  logic [31:0] r_retired_cnt;

  logic w_busy;      // an instruction is executing (EXEC or MISAL)
  logic w_all_ready; // every enabled unit reports ready
  logic w_done;      // current access/operation has finished
  logic w_split;     // finished first half of a misaligned access
  logic w_timeout;   // watchdog forces completion this cycle
  logic w_finish;    // result is presented to WB from EXEC/MISAL
  logic w_accept;    // WB takes the result this cycle

  // Completion decode: which units are done and whether the result leaves now.
  // NOTE: every signal is given a value at the top of the block. This prevents
  // a latch when a branch below does not assign the signal.
  always_comb begin
    w_busy      = (r_state == S_EXEC) || (r_state == S_MISAL);
    w_all_ready = (~alu_en_i  | alu_ready_i) &
                  (~mult_en_i | mult_ready_i) &
                  (~data_req_i | lsu_ready_i);
    w_done      = (r_state == S_MISAL) ? lsu_ready_i : w_all_ready;
    // The misalignment request is honoured once; in MISAL it is ignored.
    w_split     = (r_state == S_EXEC) & w_done & data_misaligned_i;
    w_finish    = w_busy & ~w_split & (w_done | w_timeout);
  end

  // Handshake outputs: purely a function of the state and the ready/done terms.
  always_comb begin
    ex_valid_o           = w_finish | (r_state == S_HOLD);
    ex_ready_o           = (r_state == S_IDLE) | (ex_valid_o & wb_ready_i);
    mult_multicycle_o    = (r_state == S_EXEC) & mult_en_i & ~mult_ready_i;
    data_misaligned_ex_o = (r_state == S_MISAL);
    w_accept             = ex_valid_o & wb_ready_i;
  end

  // Instruction lifecycle FSM: issue, execute, optional second access, hold.
  // NOTE: registers use non-blocking assignments. All flops then see the values
  // from before the clock edge, whatever the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (issue_valid_i) r_state <= S_EXEC;
        end
        S_EXEC, S_MISAL: begin
          if (w_split) begin
            r_state <= S_MISAL;
          end else if (w_finish) begin
            if (wb_ready_i) r_state <= issue_valid_i ? S_EXEC : S_IDLE;
            else            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (wb_ready_i) r_state <= issue_valid_i ? S_EXEC : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_retired_cnt <= '0;
    else if (w_accept) r_retired_cnt <= r_retired_cnt + 32'd1;
  end

  assign retired_cnt_o = r_retired_cnt;

`ifdef CV32E40P_FT_EX_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wd;

  assign w_timeout = w_busy & ~w_done & (r_wd == WD_LAST);

  // Watchdog: counts stalled cycles of the current EXEC/MISAL phase and
  // restarts whenever a phase begins or ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_wd <= '0;
    else if (w_busy & ~w_finish & ~w_split) r_wd <= r_wd + 8'd1;
    else                                 r_wd <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign ft_timeout_o = w_timeout;

endmodule

// File: tb/tb_cv32e40p_ex_issue_ctrl.sv
// Testbench for cv32e40p_ex_issue_ctrl. It applies a directed vector table and
// hand-written corner sequences, then runs randomized traffic against a
// transaction-level reference model.
module tb_cv32e40p_ex_issue_ctrl;

  localparam int TO = 8;
`ifdef CV32E40P_FT_EX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid_i, alu_en_i, mult_en_i, data_req_i;
  logic        alu_ready_i, mult_ready_i, lsu_ready_i, data_misaligned_i, wb_ready_i;
  logic        ex_ready_o, ex_valid_o, mult_multicycle_o, data_misaligned_ex_o;
  logic [31:0] retired_cnt_o;
  logic        ft_timeout_o;

  cv32e40p_ex_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .issue_valid_i        (issue_valid_i),
    .alu_en_i             (alu_en_i),
    .mult_en_i            (mult_en_i),
    .data_req_i           (data_req_i),
    .alu_ready_i          (alu_ready_i),
    .mult_ready_i         (mult_ready_i),
    .lsu_ready_i          (lsu_ready_i),
    .data_misaligned_i    (data_misaligned_i),
    .wb_ready_i           (wb_ready_i),
    .ex_ready_o           (ex_ready_o),
    .ex_valid_o           (ex_valid_o),
    .mult_multicycle_o    (mult_multicycle_o),
    .data_misaligned_ex_o (data_misaligned_ex_o),
    .retired_cnt_o        (retired_cnt_o),
    .ft_timeout_o         (ft_timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Input bit order: {iv, alu_en, mult_en, req, alu_rdy, mult_rdy, lsu_rdy, mis, wb}
  task automatic set_in(input logic [8:0] v);
    {issue_valid_i, alu_en_i, mult_en_i, data_req_i, alu_ready_i,
     mult_ready_i, lsu_ready_i, data_misaligned_i, wb_ready_i} = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [8:0]  in;
    logic [3:0]  exp;   // {ex_ready, ex_valid, mult_multicycle, data_misaligned_ex}
    logic [31:0] cnt;   // retired count expected during this cycle
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic [8:0] i, input logic [3:0] e, input logic [31:0] c);
    vec_t v;
    v.in  = i;
    v.exp = e;
    v.cnt = c;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // One in-flight instruction, described by three flags: executing, performing
  // its second (misaligned) access, or waiting for WB. m_age counts the stalled
  // cycles of the current phase.
  bit          m_busy, m_second, m_hold;
  int          m_age;
  logic [31:0] m_cnt;
  bit          e_ready, e_valid, e_mmc, e_mex, e_to;
  bit          e_split, e_end;

  task automatic model_reset();
    m_busy = 0; m_second = 0; m_hold = 0; m_age = 0; m_cnt = '0;
  endtask

  task automatic model_eval();
    bit all_rdy, done;
    e_ready = 1; e_valid = 0; e_mmc = 0; e_mex = 0; e_to = 0; e_split = 0; e_end = 0;
    if (m_hold) begin
      e_valid = 1;
      e_ready = wb_ready_i;
    end else if (m_busy) begin
      all_rdy = (!alu_en_i || alu_ready_i) && (!mult_en_i || mult_ready_i) &&
                (!data_req_i || lsu_ready_i);
      done    = m_second ? lsu_ready_i : all_rdy;
      e_mex   = m_second;
      e_mmc   = !m_second && mult_en_i && !mult_ready_i;
      e_to    = TO_EN && !done && (m_age == TO - 1);
      e_split = !m_second && done && data_misaligned_i;
      e_end   = !e_split && (done || e_to);
      e_valid = e_end;
      e_ready = e_end && wb_ready_i;
    end
  endtask

  task automatic model_advance();
    if (e_valid && wb_ready_i) m_cnt = m_cnt + 1;
    if (m_hold) begin
      if (wb_ready_i) begin m_hold = 0; m_busy = issue_valid_i; m_second = 0; m_age = 0; end
    end else if (m_busy) begin
      if (e_split) begin
        m_second = 1; m_age = 0;
      end else if (e_end) begin
        m_second = 0; m_age = 0;
        if (wb_ready_i) m_busy = issue_valid_i;
        else begin m_busy = 0; m_hold = 1; end
      end else begin
        m_age++;
      end
    end else begin
      m_busy = issue_valid_i; m_age = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in('0);
    #1;
    check("rst_ready", ex_ready_o, 1);
    check("rst_valid", ex_valid_o, 0);
    check("rst_mmc", mult_multicycle_o, 0);
    check("rst_mex", data_misaligned_ex_o, 0);
    check("rst_cnt", retired_cnt_o, 0);
    check("rst_ft", ft_timeout_o, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int pulse_at;
    int n_pulse;
    int n_valid;

    tbl[0]  = mk(9'b101000001, 4'b1000, 0);
    tbl[1]  = mk(9'b001000001, 4'b0010, 0);
    tbl[2]  = mk(9'b001000001, 4'b0010, 0);
    tbl[3]  = mk(9'b001000001, 4'b0010, 0);
    tbl[4]  = mk(9'b001001001, 4'b1100, 0);
    tbl[5]  = mk(9'b100100110, 4'b1000, 1);
    tbl[6]  = mk(9'b000100111, 4'b0000, 1);
    tbl[7]  = mk(9'b000100011, 4'b0001, 1);
    tbl[8]  = mk(9'b000100001, 4'b0001, 1);
    tbl[9]  = mk(9'b000100101, 4'b1101, 1);
    tbl[10] = mk(9'b110010000, 4'b1000, 2);
    tbl[11] = mk(9'b010010000, 4'b0100, 2);
    tbl[12] = mk(9'b010010000, 4'b0100, 2);
    tbl[13] = mk(9'b010010000, 4'b0100, 2);
    tbl[14] = mk(9'b010010000, 4'b0100, 2);
    tbl[15] = mk(9'b010010000, 4'b0100, 2);
    tbl[16] = mk(9'b010010001, 4'b1100, 2);
    tbl[17] = mk(9'b110010001, 4'b1000, 3);
    tbl[18] = mk(9'b110010001, 4'b1100, 3);
    tbl[19] = mk(9'b110010001, 4'b1100, 4);
    tbl[20] = mk(9'b110010001, 4'b1100, 5);
    tbl[21] = mk(9'b010010001, 4'b1100, 6);
    tbl[22] = mk(9'b100000001, 4'b1000, 7);
    tbl[23] = mk(9'b000000001, 4'b1100, 7);
    tbl[24] = mk(9'b000000000, 4'b1000, 8);

    do_reset();

    // Directed table: multicycle mult, misaligned LSU, WB back-pressure,
    // back-to-back ALU stream, instruction with no unit enabled.
    for (int i = 0; i < 25; i++) begin
      set_in(tbl[i].in);
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), ex_ready_o, tbl[i].exp[3]);
      check($sformatf("vec%0d_valid", i), ex_valid_o, tbl[i].exp[2]);
      check($sformatf("vec%0d_mmc", i), mult_multicycle_o, tbl[i].exp[1]);
      check($sformatf("vec%0d_mex", i), data_misaligned_ex_o, tbl[i].exp[0]);
      check($sformatf("vec%0d_cnt", i), retired_cnt_o, tbl[i].cnt);
      check($sformatf("vec%0d_ft", i), ft_timeout_o, 0);
      next_cycle();
    end

    // Counter wrap across a 5-cycle WB stall.
    dut.r_retired_cnt = 32'hFFFF_FFFF;
    set_in(9'b110010000);
    @(negedge clk);
    check("wrap_pre_cnt", retired_cnt_o, 32'hFFFF_FFFF);
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      set_in((k == 5) ? 9'b010010001 : 9'b010010000);
      @(negedge clk);
      check($sformatf("hold%0d_valid", k), ex_valid_o, 1);
      check($sformatf("hold%0d_ready", k), ex_ready_o, (k == 5) ? 1 : 0);
      check($sformatf("hold%0d_cnt", k), retired_cnt_o, 32'hFFFF_FFFF);
      next_cycle();
    end
    set_in('0);
    @(negedge clk);
    check("wrap_cnt", retired_cnt_o, 0);
    check("wrap_valid", ex_valid_o, 0);
    next_cycle();

    // Reset while a multiplier instruction is pending.
    set_in(9'b110010001);
    next_cycle();
    set_in(9'b010010001);
    next_cycle();
    set_in(9'b101000001);
    next_cycle();
    set_in(9'b001000001);
    @(negedge clk);
    check("pre_rst_mmc", mult_multicycle_o, 1);
    check("pre_rst_cnt", retired_cnt_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", ex_valid_o, 0);
    check("midrst_ready", ex_ready_o, 1);
    check("midrst_mmc", mult_multicycle_o, 0);
    check("midrst_cnt", retired_cnt_o, 0);
    next_cycle();
    rst_n = 1'b1;
    set_in(9'b001001001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("postrst%0d_valid", k), ex_valid_o, 0);
      check($sformatf("postrst%0d_ready", k), ex_ready_o, 1);
      check($sformatf("postrst%0d_cnt", k), retired_cnt_o, 0);
      next_cycle();
    end

    // ALU never ready: watchdog behaviour (bounded either way).
    set_in(9'b110000001);
    next_cycle();
    set_in(9'b010000001);
    pulse_at = 0;
    n_pulse  = 0;
    n_valid  = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (ft_timeout_o) begin
        n_pulse++;
        if (pulse_at == 0) begin
          pulse_at = n;
          check("wd_valid", ex_valid_o, 1);
        end
      end else if (pulse_at == 0 && ex_valid_o) begin
        n_valid++;
      end
      next_cycle();
    end
    if (TO_EN) begin
      check("wd_pulse_cycle", pulse_at, TO);
      check("wd_early_valid", n_valid, 0);
    end else begin
      check("nowd_pulses", n_pulse, 0);
      check("nowd_valids", n_valid, 0);
      check("nowd_stalled", ex_ready_o, 0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      issue_valid_i     = ($urandom_range(0, 99) < 50);
      alu_en_i          = ($urandom_range(0, 99) < 50);
      mult_en_i         = ($urandom_range(0, 99) < 30);
      data_req_i        = ($urandom_range(0, 99) < 40);
      alu_ready_i       = ($urandom_range(0, 99) < 80);
      mult_ready_i      = ($urandom_range(0, 99) < 60);
      lsu_ready_i       = ($urandom_range(0, 99) < 70);
      data_misaligned_i = ($urandom_range(0, 99) < 25);
      wb_ready_i        = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      model_eval();
      check("rnd_ready", ex_ready_o, e_ready);
      check("rnd_valid", ex_valid_o, e_valid);
      check("rnd_mmc", mult_multicycle_o, e_mmc);
      check("rnd_mex", data_misaligned_ex_o, e_mex);
      check("rnd_ft", ft_timeout_o, e_to);
      check("rnd_cnt", retired_cnt_o, m_cnt);
      model_advance();
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
